spi_rx_monitor: RTL and testbench
=================================

Name: spi_rx_monitor

Overview:
- Oversampled SPI responder: the receiving end of the 16-bit motor-speed link driven by the SPI master toward the PMD901.
- Samples sclk/cs_n/mosi on the 100 MHz system clock, assembles MSB-first frames, and presents each completed word with a one-cycle valid strobe.
- Flags malformed frames: short frames and frames with extra clocks.
- Used as the PMD901-side model in system benches and as an on-chip loopback checker.

Parameters:
- DATA_WIDTH, 16, bits per frame; legal range 2..32.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n, mosi; minimum 2.
- MIN_GAP_CYCLES, 12'd2000, minimum cs_n-high time in clk cycles between frames. Used only with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz, at least 4x sclk frequency
- rst  input  1  asynchronous active-high reset
- sclk  input  1  SPI clock from initiator, CPOL=0, asynchronous to clk
- cs_n  input  1  SPI chip select, active low, asynchronous
- mosi  input  1  SPI serial data, asynchronous
- fault_clr  input  1  synchronous clear of the sticky fault flag
- rx_data  output  DATA_WIDTH  last good frame, MSB = first bit received
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle
- frame_err  output  1  one-cycle strobe: malformed frame discarded
- busy  output  1  high while a frame is in progress (state != IDLE)
- fault  output  1  sticky error flag; set by frame_err (or gap_err), cleared by fault_clr
- gap_err  output  1  one-cycle strobe; present only with SPI_RX_GAP_CHECK_EN

Behaviour:
- Reset (async on rst high): rx_data=0, rx_valid=0, frame_err=0, busy=0, fault=0, gap_err=0, state=IDLE, bit_cnt=0, shift register=0. Synchronizer flops reset to the idle levels: sclk=0, cs_n=1, mosi=0.
- sclk, cs_n and mosi all pass through identical SYNC_STAGES chains, so they stay mutually aligned.
- Edge detection uses one further registered copy of each synchronized signal. sclk_rise = sync 1 and previous 0; cs_fall and cs_rise are defined likewise.
- Data is sampled on sclk_rise using the synchronized mosi of the same cycle, shifted in MSB first.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: sclk edges are ignored. cs_fall -> SHIFT, with bit_cnt=0.
  - SHIFT: each sclk_rise shifts in one bit and increments bit_cnt. When bit_cnt reaches DATA_WIDTH -> HOLD. cs_rise before that -> frame_err pulse, fault=1, IDLE; rx_data unchanged.
  - HOLD: cs_rise -> rx_data <= shift register, rx_valid pulse, IDLE. Any sclk_rise in HOLD sets an internal overflow flag; the following cs_rise then gives frame_err instead of rx_valid.
- Simultaneous sclk_rise and cs_rise in the same clk: cs_rise wins and the sclk edge is ignored.
- cs_fall while not in IDLE cannot occur without a prior cs_rise, so no handling is required.
- Latency: rx_valid or frame_err asserts exactly SYNC_STAGES+2 clk cycles after the cs_n pin rises, measured with a synchronous testbench edge.
- rx_valid and frame_err are never high together.
- fault_clr has priority below a same-cycle set: set wins.
- busy = (state != IDLE).
- Reset asserted mid-frame aborts the frame with no strobe. The next frame after reset release is received normally, provided cs_n was high for at least SYNC_STAGES+1 cycles before its fall.

Optional Feature:
- Macro: SPI_RX_GAP_CHECK_EN.
- Defined:
  - A 12-bit counter counts clk cycles in IDLE, saturating at 4095, and is cleared on each rx_valid or frame_err.
  - On cs_fall with count < MIN_GAP_CYCLES, gap_err pulses for one cycle and fault is set. The frame is still received normally.
  - The first frame after reset is exempt.
- Undefined: no counter, and gap_err is tied to 0.

Test Plan:
- Good frame: reset, then send 16'hA5C3 with sclk = clk/16 and the full handshake -> one rx_valid, rx_data=16'hA5C3, frame_err=0, fault=0, and strobe latency SYNC_STAGES+2 after the cs_n rise.
- Short frame: cs_n low, 10 sclk pulses, cs_n high -> frame_err for 1 cycle, fault=1, rx_data keeps its previous value. Then fault_clr=1 for 1 cycle -> fault=0.
- Long frame: 17 sclk pulses with data 16'hFFFF then an extra bit -> frame_err, no rx_valid, rx_data unchanged.
- Back-to-back frames: 16'h0001 then 16'h8000 with a 2001-cycle gap -> two rx_valid strobes with the correct data in order. With SPI_RX_GAP_CHECK_EN and a repeat using a 100-cycle gap -> gap_err on the second cs_fall, fault=1, and the second word still delivered.
- Reset mid-frame: assert rst after 8 bits of 16'h1234, release it, then send 16'h5678 -> no strobe for the aborted frame; rx_valid with rx_data=16'h5678.
- Edge race: the 16th sclk_rise and the cs_n rise in the same synchronized cycle -> frame_err (15 bits counted), no rx_valid.

Source files
------------

// File: rtl/spi_rx_monitor_if.sv
// Bus bundle for spi_rx_monitor: SPI pins plus the receive/status side.
// master drives the SPI pins and fault_clr; slave is the monitor itself.
interface spi_rx_monitor_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  fault_clr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;
  logic                  fault;
  logic                  gap_err;

  modport master (
    output sclk, cs_n, mosi, fault_clr,
    input  rx_data, rx_valid, frame_err, busy, fault, gap_err
  );

  modport slave (
    input  sclk, cs_n, mosi, fault_clr,
    output rx_data, rx_valid, frame_err, busy, fault, gap_err
  );
endinterface

// File: rtl/spi_rx_monitor.sv
// Oversampled SPI responder: collects MSB-first frames, strobes good words, flags malformed ones.
// Optional inter-frame gap checking is enabled by defining SPI_RX_GAP_CHECK_EN.
module spi_rx_monitor #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [11:0] MIN_GAP_CYCLES = 12'd2000
) (
  input  logic             clk,
  input  logic             rst,
  spi_rx_monitor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   r_sclk_rise, r_cs_fall, r_cs_rise, r_mosi_smp;
  logic                   w_sclk, w_cs, w_mosi;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic                   r_overflow;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid, r_frame_err, r_fault, r_gap_err;
  logic                   w_frame_end, w_good, w_bad, w_gap_set;

  // Identical synchronizer chains keep sclk, cs_n and mosi mutually aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Edge strobes and the matching mosi sample are registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_rise <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_mosi_smp  <= 1'b0;
    end else begin
      r_sclk_rise <= w_sclk & ~r_sclk_d;
      r_cs_fall   <= ~w_cs & r_cs_d;
      r_cs_rise   <= w_cs & ~r_cs_d;
      r_mosi_smp  <= w_mosi;
    end
  end

  assign w_frame_end = r_cs_rise & (r_state != IDLE);
  assign w_good      = r_cs_rise & (r_state == HOLD) & ~r_overflow;
  assign w_bad       = w_frame_end & ~w_good;

`ifdef SPI_RX_GAP_CHECK_EN
  logic [11:0] r_gap_cnt;
  logic        r_first;

  assign w_gap_set = (r_state == IDLE) & r_cs_fall & ~r_first & (r_gap_cnt < MIN_GAP_CYCLES);

  // Idle-time counter; the first frame after reset has no meaningful gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
      r_first   <= 1'b1;
      r_gap_err <= 1'b0;
    end else begin
      r_gap_err <= w_gap_set;
      if (w_frame_end) begin
        r_gap_cnt <= '0;
      end else if ((r_state == IDLE) && (r_gap_cnt != 12'hFFF)) begin
        r_gap_cnt <= r_gap_cnt + 12'd1;
      end
      if ((r_state == IDLE) && r_cs_fall) begin
        r_first <= 1'b0;
      end
    end
  end
`else
  assign w_gap_set = 1'b0;
  assign r_gap_err = 1'b0 & (|MIN_GAP_CYCLES);
`endif

  // Frame FSM with registered strobes; a cs rise always beats a same-cycle sclk rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_overflow  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_rx_valid  <= w_good;
      r_frame_err <= w_bad;
      if (w_bad || w_gap_set) begin
        r_fault <= 1'b1;
      end else if (bus.fault_clr) begin
        r_fault <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (r_cs_fall) begin
            r_state    <= SHIFT;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_cs_rise) begin
            r_state <= IDLE;
          end else if (r_sclk_rise) begin
            r_shift   <= {r_shift[DATA_WIDTH-2:0], r_mosi_smp};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (r_cs_rise) begin
            r_state <= IDLE;
            if (!r_overflow) begin
              r_rx_data <= r_shift;
            end
          end else if (r_sclk_rise) begin
            r_overflow <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.fault     = r_fault;
  assign bus.gap_err   = r_gap_err;

endmodule

// File: tb/tb_spi_rx_monitor.sv
// Self-checking bench for spi_rx_monitor: directed scenarios plus random frames
// scored against a frame-level model (word accepted only when exactly DATA_WIDTH bits arrive).
module tb_spi_rx_monitor;

  localparam int unsigned DW   = 16;
  localparam int unsigned SYNC = 2;
  localparam int          LAT  = SYNC + 2;
  localparam int          GAP  = 2010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_rx_monitor_if #(.DATA_WIDTH(DW)) bus ();

  spi_rx_monitor #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SYNC),
    .MIN_GAP_CYCLES(12'd2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_rise  = 0;
  int cnt_valid  = 0;
  int cnt_err    = 0;
  int cnt_gap    = 0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe counters; valid and error must never coincide
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid)  cnt_valid = cnt_valid + 1;
      if (bus.frame_err) cnt_err   = cnt_err + 1;
      if (bus.gap_err)   cnt_gap   = cnt_gap + 1;
      if (bus.rx_valid && bus.frame_err) begin
        miscompares = miscompares + 1;
        $display("FAIL strobe_overlap: rx_valid=1 frame_err=1 at cycle %0d, required not both", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends nbits of data MSB first after waiting for a cs_n-high gap; race puts the last sclk rise on the cs_n rise
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit race, input int gap,
                            output int nv, output int ne, output int lat,
                            output logic [DW-1:0] got_data, output logic got_fault, output logic busy_mid);
    int v0, e0;
    logic [31:0] sh;
    while (cyc - last_rise < gap) tick(1);
    v0 = cnt_valid;
    e0 = cnt_err;
    lat = -1;
    got_data = 'x;
    got_fault = 1'bx;
    busy_mid = 1'b0;
    bus.cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      sh = data << (32 - DW + i);
      bus.mosi = (i < int'(DW)) ? sh[31] : 1'b1;
      tick(8);
      bus.sclk = 1'b1;
      if (race && i == nbits - 1) begin
        bus.cs_n = 1'b1;
      end else begin
        tick(8);
        if (i == 0) busy_mid = bus.busy;
        bus.sclk = 1'b0;
      end
    end
    if (!race) begin
      tick(8);
      bus.cs_n = 1'b1;
    end
    last_rise = cyc;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (lat < 0 && (bus.rx_valid || bus.frame_err)) begin
        lat = k;
        got_data = bus.rx_data;
        got_fault = bus.fault;
      end
    end
    bus.sclk = 1'b0;
    nv = cnt_valid - v0;
    ne = cnt_err - e0;
  endtask

  task automatic clear_fault();
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.fault_clr = 1'b0;
    tick(5);
    vectors += 6;
    if (bus.rx_data !== '0) begin miscompares++; $display("FAIL reset_rx_data: got %h want 0", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    if (bus.gap_err !== 1'b0) begin miscompares++; $display("FAIL reset_gap_err: got %b want 0", bus.gap_err); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_good_frame();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    send_frame(32'h0000_A5C3, DW, 1'b0, GAP, nv, ne, lat, d, f, b);
    exp_data = 16'hA5C3;
    vectors += 6;
    if (nv !== 1 || ne !== 0) begin miscompares++; $display("FAIL good_strobes: valid=%0d err=%0d want 1/0", nv, ne); end
    if (d !== exp_data) begin miscompares++; $display("FAIL good_data: got %h want %h", d, exp_data); end
    if (lat !== LAT) begin miscompares++; $display("FAIL good_latency: got %0d want %0d", lat, LAT); end
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL good_fault: got %b want 0", bus.fault); end
    if (b !== 1'b1) begin miscompares++; $display("FAIL good_busy_mid: got %b want 1", b); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL good_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_short_frame();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    send_frame(32'h0000_3C3C, 10, 1'b0, GAP, nv, ne, lat, d, f, b);
    vectors += 5;
    if (nv !== 0 || ne !== 1) begin miscompares++; $display("FAIL short_strobes: valid=%0d err=%0d want 0/1", nv, ne); end
    if (lat !== LAT) begin miscompares++; $display("FAIL short_latency: got %0d want %0d", lat, LAT); end
    if (bus.rx_data !== exp_data) begin miscompares++; $display("FAIL short_data_kept: got %h want %h", bus.rx_data, exp_data); end
    if (bus.fault !== 1'b1) begin miscompares++; $display("FAIL short_fault_set: got %b want 1", bus.fault); end
    clear_fault();
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL short_fault_clr: got %b want 0", bus.fault); end
  endtask

  task automatic test_long_frame();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    send_frame(32'h0000_FFFF, DW + 1, 1'b0, GAP, nv, ne, lat, d, f, b);
    vectors += 3;
    if (nv !== 0 || ne !== 1) begin miscompares++; $display("FAIL long_strobes: valid=%0d err=%0d want 0/1", nv, ne); end
    if (bus.rx_data !== exp_data) begin miscompares++; $display("FAIL long_data_kept: got %h want %h", bus.rx_data, exp_data); end
    if (bus.fault !== 1'b1) begin miscompares++; $display("FAIL long_fault: got %b want 1", bus.fault); end
    clear_fault();
  endtask

  task automatic test_fault_set_wins();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    bus.fault_clr = 1'b1;
    send_frame(32'h0000_0F0F, 5, 1'b0, GAP, nv, ne, lat, d, f, b);
    vectors += 2;
    if (f !== 1'b1) begin miscompares++; $display("FAIL set_wins_fault: got %b want 1", f); end
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL set_wins_then_clr: got %b want 0", bus.fault); end
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    int g0;
    logic [DW-1:0] words [2];
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    g0 = cnt_gap;
    for (int w = 0; w < 2; w++) begin
      send_frame({16'h0, words[w]}, DW, 1'b0, 2001, nv, ne, lat, d, f, b);
      exp_data = words[w];
      vectors += 2;
      if (nv !== 1 || ne !== 0) begin miscompares++; $display("FAIL b2b_strobes[%0d]: valid=%0d err=%0d want 1/0", w, nv, ne); end
      if (d !== exp_data) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", w, d, exp_data); end
    end
    vectors += 2;
    if (cnt_gap !== g0) begin miscompares++; $display("FAIL b2b_no_gap_err: got %0d want %0d", cnt_gap, g0); end
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL b2b_fault: got %b want 0", bus.fault); end
  endtask

`ifdef SPI_RX_GAP_CHECK_EN
  task automatic test_gap_check();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    int g0;
    send_frame(32'h0000_0001, DW, 1'b0, GAP, nv, ne, lat, d, f, b);
    exp_data = 16'h0001;
    g0 = cnt_gap;
    send_frame(32'h0000_8000, DW, 1'b0, 100, nv, ne, lat, d, f, b);
    exp_data = 16'h8000;
    vectors += 4;
    if (cnt_gap - g0 !== 1) begin miscompares++; $display("FAIL gap_err_count: got %0d want 1", cnt_gap - g0); end
    if (bus.fault !== 1'b1) begin miscompares++; $display("FAIL gap_fault: got %b want 1", bus.fault); end
    if (nv !== 1 || ne !== 0) begin miscompares++; $display("FAIL gap_strobes: valid=%0d err=%0d want 1/0", nv, ne); end
    if (d !== exp_data) begin miscompares++; $display("FAIL gap_data: got %h want %h", d, exp_data); end
    clear_fault();
  endtask
`endif

  task automatic test_random();
    int nv, ne, lat, nbits; logic [DW-1:0] d; logic f, b;
    logic [31:0] data;
    bit exp_ok;
    for (int n = 0; n < 8; n++) begin
      data  = $urandom;
      nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW + 2)) : int'(DW);
      send_frame(data, nbits, 1'b0, GAP, nv, ne, lat, d, f, b);
      exp_ok = (nbits == int'(DW));
      if (exp_ok) exp_data = data[DW-1:0];
      vectors += 4;
      if (nv !== (exp_ok ? 1 : 0) || ne !== (exp_ok ? 0 : 1)) begin
        miscompares++; $display("FAIL rand_strobes[%0d]: bits=%0d valid=%0d err=%0d", n, nbits, nv, ne);
      end
      if (bus.rx_data !== exp_data) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", n, bus.rx_data, exp_data); end
      if (lat !== LAT) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); end
      if (bus.fault !== !exp_ok) begin miscompares++; $display("FAIL rand_fault[%0d]: got %b want %b", n, bus.fault, !exp_ok); end
      clear_fault();
    end
  endtask

  task automatic test_reset_mid_frame();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    int v0, e0;
    logic [31:0] sh;
    while (cyc - last_rise < GAP) tick(1);
    v0 = cnt_valid;
    e0 = cnt_err;
    bus.cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      sh = 32'h0000_1234 << (32 - DW + i);
      bus.mosi = sh[31];
      tick(8);
      bus.sclk = 1'b1;
      tick(8);
      bus.sclk = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors += 2;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    if (bus.rx_data !== '0) begin miscompares++; $display("FAIL rstmid_rx_data: got %h want 0", bus.rx_data); end
    exp_data = '0;
    bus.cs_n = 1'b1;
    tick(5);
    rst = 1'b0;
    last_rise = cyc;
    tick(20);
    vectors += 1;
    if (cnt_valid !== v0 || cnt_err !== e0) begin
      miscompares++; $display("FAIL rstmid_no_strobe: valid+%0d err+%0d want 0/0", cnt_valid - v0, cnt_err - e0);
    end
    send_frame(32'h0000_5678, DW, 1'b0, 50, nv, ne, lat, d, f, b);
    exp_data = 16'h5678;
    vectors += 3;
    if (nv !== 1 || ne !== 0) begin miscompares++; $display("FAIL rstmid_strobes: valid=%0d err=%0d want 1/0", nv, ne); end
    if (d !== exp_data) begin miscompares++; $display("FAIL rstmid_data: got %h want %h", d, exp_data); end
    if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL rstmid_fault: got %b want 0", bus.fault); end
  endtask

  task automatic test_edge_race();
    int nv, ne, lat; logic [DW-1:0] d; logic f, b;
    send_frame(32'h0000_C0DE, DW, 1'b1, GAP, nv, ne, lat, d, f, b);
    vectors += 3;
    if (nv !== 0 || ne !== 1) begin miscompares++; $display("FAIL race_strobes: valid=%0d err=%0d want 0/1", nv, ne); end
    if (bus.rx_data !== exp_data) begin miscompares++; $display("FAIL race_data_kept: got %h want %h", bus.rx_data, exp_data); end
    if (lat !== LAT) begin miscompares++; $display("FAIL race_latency: got %0d want %0d", lat, LAT); end
    clear_fault();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_fault_set_wins();
    test_back_to_back();
`ifdef SPI_RX_GAP_CHECK_EN
    test_gap_check();
`endif
    test_random();
    test_reset_mid_frame();
    test_edge_race();
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
